// File: rtl/spi_txn_arbiter.sv
// Purpose: round-robin sharing of one SPI byte engine and its slave selects among N requesters.
// Latency: grant one cycle after req is seen in IDLE; CS_DLY setup cycles precede the first spi_start.
// Backpressure: stalls in START while spi_ready is low; other requesters wait until done.
module spi_txn_arbiter #(
    parameter int N      = 2,
    parameter int S      = 2,
    parameter int SW     = 1,
    parameter int LW     = 8,
    parameter int CS_DLY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*LW-1:0] req_len,
    input  logic [N*SW-1:0] req_ss,
    input  logic [N*8-1:0]  tx_byte,
    output logic [N-1:0]    gnt,
    output logic            tx_ack,
    output logic            rx_valid,
    output logic [7:0]      rx_byte,
    output logic [N-1:0]    done,
    output logic            busy,
    output logic            spi_start,
    output logic [7:0]      spi_din,
    input  logic [7:0]      spi_dout,
    input  logic            spi_ready,
    input  logic            spi_done_tick,
    output logic [S-1:0]    spi_ss_n
);
    localparam int IW = $clog2(N);
    localparam int DW = $clog2(CS_DLY + 1);

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   g_idx_q, g_idx_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [LW-1:0]   len_q, len_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic [S-1:0]    ss_n_q, ss_n_d;

    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [LW-1:0]   pick_len;
    logic [SW-1:0]   pick_ss;
    logic [S-1:0]    pick_ss_n;
    logic [7:0]      tx_sel;

    // Index k places above base, wrapping at N.
    function automatic logic [IW-1:0] rr_at(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign spi_ss_n = ss_n_q;
    assign busy     = (state_q != IDLE);

    // Round-robin pick from rr pointer upward, plus field muxing for the picked and granted requesters.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[rr_at(rr_q, k)]) begin
                pick_vld = 1'b1;
                pick_idx = rr_at(rr_q, k);
            end
        end
        pick_len = '0;
        pick_ss  = '0;
        tx_sel   = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_len = req_len[i*LW +: LW];
                pick_ss  = req_ss[i*SW +: SW];
            end
            if (g_idx_q == IW'(i)) tx_sel = tx_byte[i*8 +: 8];
        end
        // An out-of-range slave index matches no line, so every select stays high.
        pick_ss_n = '1;
        for (int j = 0; j < S; j++) begin
            if (pick_ss == SW'(j)) pick_ss_n[j] = 1'b0;
        end
    end

    // Next-state and handshake outputs; engine-facing strobes are combinational so they track spi_ready/spi_done_tick.
    always_comb begin
        state_d   = state_q;
        g_idx_d   = g_idx_q;
        rr_d      = rr_q;
        len_d     = len_q;
        dly_d     = dly_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        ss_n_d    = ss_n_q;
        spi_start = 1'b0;
        tx_ack    = 1'b0;
        spi_din   = '0;
        rx_valid  = 1'b0;
        rx_byte   = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d         = SETUP;
                    g_idx_d         = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    len_d           = (pick_len == '0) ? LW'(1) : pick_len;
                    dly_d           = DW'(CS_DLY);
                    ss_n_d          = pick_ss_n;
                end
            end
            SETUP: begin
                if (dly_q <= DW'(1)) state_d = START;
                else                 dly_d   = dly_q - DW'(1);
            end
            START: begin
                if (spi_ready) begin
                    spi_start = 1'b1;
                    tx_ack    = 1'b1;
                    spi_din   = tx_sel;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (spi_done_tick) begin
                    rx_valid = 1'b1;
                    rx_byte  = spi_dout;
                    if (len_q > LW'(1)) begin
                        len_d   = len_q - LW'(1);
                        state_d = START;
                    end else begin
                        dly_d   = DW'(CS_DLY);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (dly_q <= DW'(1)) begin
                    state_d = IDLE;
                    ss_n_d  = '1;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    rr_d    = rr_at(g_idx_q, 1);
                end else begin
                    dly_d = dly_q - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any transaction in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            g_idx_q <= '0;
            rr_q    <= '0;
            len_q   <= '0;
            dly_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ss_n_q  <= '1;
        end else begin
            state_q <= state_d;
            g_idx_q <= g_idx_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            dly_q   <= dly_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ss_n_q  <= ss_n_d;
        end
    end
endmodule
